// File: rtl/pool_layer_np.sv
// pool_layer_np: channel-parallel max/average pooling over a feature map held
// in an internal single-port buffer. The host loads the buffer while idle,
// pulses layer_enable, and receives one pooled word per window on out_bus
// with a sequential out_addr, followed by a one-cycle layer_done pulse.
//
// Datapath: read address (counters) -> buffer read (_p0) -> per-channel
// accumulate (_p1); the window's last sample is folded straight into the
// registered output so no extra output stage is added.
module pool_layer_np #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_NUM     = 6,
    parameter int ADDR_WIDTH = 16,
    parameter int IN_W       = 28,
    parameter int IN_H       = 28,
    parameter int POOL_K     = 2,
    parameter int STRIDE     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         layer_enable,
    input  logic                         pool_mode,
    input  logic                         in_wr_en,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [CH_NUM*DATA_WIDTH-1:0] in_data_bus,
    output logic                         busy,
    output logic [CH_NUM*DATA_WIDTH-1:0] out_bus,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic                         out_wr_en,
    output logic                         layer_done
);

    localparam int BUS_W  = CH_NUM * DATA_WIDTH;
    localparam int DEPTH  = IN_W * IN_H;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LOG2K  = $clog2(POOL_K);
    localparam int SH     = 2 * LOG2K;
    localparam int ACC_W  = DATA_WIDTH + SH;
    localparam int KW     = (LOG2K > 0) ? LOG2K : 1;
    localparam int OUT_W  = (IN_W - POOL_K) / STRIDE + 1;
    localparam int OUT_H  = (IN_H - POOL_K) / STRIDE + 1;
    localparam int OXW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OYW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    // The averaging divide is a plain arithmetic shift, so the window size
    // has to be a power of two.
    generate
        if (POOL_K < 1 || (POOL_K & (POOL_K - 1)) != 0) begin : g_bad_pool_k
            $error("pool_layer_np: POOL_K must be a power of two");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t state;
    logic   mode;       // latched pool_mode: 0 = max, 1 = average
    logic   issuing;    // a buffer read is issued this cycle

    // Window walk counters: output position (ox, oy) and offset inside the window (kx, ky)
    logic [KW-1:0]  kx;
    logic [KW-1:0]  ky;
    logic [OXW-1:0] ox;
    logic [OYW-1:0] oy;
    logic [ADDR_WIDTH-1:0] out_cnt;

    logic [MEM_AW-1:0] rd_addr;
    logic              last_k;
    logic              last_win;

    logic [BUS_W-1:0] mem [DEPTH];

    // ---- stage p0: buffer read data and the window position it belongs to
    logic [BUS_W-1:0] rd_data_p0;
    logic             vld_p0;
    logic             first_p0;
    logic             last_p0;
    logic             final_p0;

    // ---- stage p1: per-channel running max / sum
    logic signed [ACC_W-1:0] acc_p1   [CH_NUM];
    logic signed [ACC_W-1:0] smp_p0   [CH_NUM];
    logic signed [ACC_W-1:0] acc_next [CH_NUM];
    logic [BUS_W-1:0]        out_next;

    // Fold one sample into a running max or running sum.
    function automatic logic signed [ACC_W-1:0] combine(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [ACC_W-1:0] smp,
        input logic                    avg
    );
        if (avg) begin
            return acc + smp;
        end
        return (smp > acc) ? smp : acc;
    endfunction

    // Reduce an accumulator to an output sample: floor-divide the sum by the
    // window area (arithmetic shift) in average mode; the max already fits.
    function automatic logic signed [DATA_WIDTH-1:0] finalize(
        input logic signed [ACC_W-1:0] acc,
        input logic                    avg
    );
        if (avg) begin
            return DATA_WIDTH'(acc >>> SH);
        end
        return DATA_WIDTH'(acc);
    endfunction

    // Flat buffer address of the sample the counters currently point at.
    always_comb begin
        rd_addr = (MEM_AW'(oy) * MEM_AW'(STRIDE) + MEM_AW'(ky)) * MEM_AW'(IN_W)
                + MEM_AW'(ox) * MEM_AW'(STRIDE) + MEM_AW'(kx);
        last_k   = (kx == KW'(POOL_K - 1)) && (ky == KW'(POOL_K - 1));
        last_win = (ox == OXW'(OUT_W - 1)) && (oy == OYW'(OUT_H - 1));
    end

    // Per-channel combine of the sample just read; the first sample of a window restarts the accumulator.
    always_comb begin
        out_next = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            smp_p0[j]   = ACC_W'(signed'(rd_data_p0[j*DATA_WIDTH +: DATA_WIDTH]));
            acc_next[j] = first_p0 ? smp_p0[j] : combine(acc_p1[j], smp_p0[j], mode);
            out_next[j*DATA_WIDTH +: DATA_WIDTH] = finalize(acc_next[j], mode);
        end
    end

    // Input buffer: host writes only while idle and in range; reads feed the pooling pipeline.
    always_ff @(posedge clk) begin
        if (in_wr_en && !busy && (in_addr < ADDR_WIDTH'(DEPTH))) begin
            mem[in_addr[MEM_AW-1:0]] <= in_data_bus;
        end
        if (issuing) begin
            rd_data_p0 <= mem[rd_addr];
        end
    end

    // Accumulator update for every valid sample.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int j = 0; j < CH_NUM; j++) begin
                acc_p1[j] <= acc_next[j];
            end
        end
    end

    // Pass control FSM, window walk, pipeline flags and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode       <= 1'b0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            issuing    <= 1'b0;
            kx         <= '0;
            ky         <= '0;
            ox         <= '0;
            oy         <= '0;
            out_cnt    <= '0;
            vld_p0     <= 1'b0;
            first_p0   <= 1'b0;
            last_p0    <= 1'b0;
            final_p0   <= 1'b0;
            out_wr_en  <= 1'b0;
            out_addr   <= '0;
            out_bus    <= '0;
        end else begin
            out_wr_en  <= 1'b0;
            layer_done <= 1'b0;

            vld_p0   <= issuing;
            first_p0 <= (kx == '0) && (ky == '0);
            last_p0  <= last_k;
            final_p0 <= last_k && last_win;

            if (vld_p0 && last_p0) begin
                out_wr_en <= 1'b1;
                out_bus   <= out_next;
                out_addr  <= out_cnt;
                out_cnt   <= out_cnt + ADDR_WIDTH'(1);
            end

            case (state)
                S_IDLE: begin
                    if (layer_enable) begin
                        mode    <= pool_mode;
                        busy    <= 1'b1;
                        issuing <= 1'b1;
                        kx      <= '0;
                        ky      <= '0;
                        ox      <= '0;
                        oy      <= '0;
                        out_cnt <= '0;
                        state   <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (issuing) begin
                        if (kx == KW'(POOL_K - 1)) begin
                            kx <= '0;
                            if (ky == KW'(POOL_K - 1)) begin
                                ky <= '0;
                                if (ox == OXW'(OUT_W - 1)) begin
                                    ox <= '0;
                                    if (oy == OYW'(OUT_H - 1)) begin
                                        oy      <= '0;
                                        issuing <= 1'b0;
                                    end else begin
                                        oy <= oy + OYW'(1);
                                    end
                                end else begin
                                    ox <= ox + OXW'(1);
                                end
                            end else begin
                                ky <= ky + KW'(1);
                            end
                        end else begin
                            kx <= kx + KW'(1);
                        end
                    end
                    if (vld_p0 && final_p0) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // First DONE cycle raises layer_done; busy drops when the pulse ends.
                    if (!layer_done) begin
                        layer_done <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_layer_np.sv
// Bench for pool_layer_np: a 4x4/K2/S2 instance and a 3x3/K2/S1 instance,
// checked against a window-by-window reference model plus fixed reference values.
module tb_pool_layer_np;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic           a_en, a_mode, a_wr;
    logic [AW-1:0]  a_addr;
    logic [CH*DW-1:0] a_din;
    logic           a_busy, a_wr_out, a_done;
    logic [CH*DW-1:0] a_bus;
    logic [AW-1:0]  a_oaddr;

    logic           b_en, b_mode, b_wr;
    logic [AW-1:0]  b_addr;
    logic [CH*DW-1:0] b_din;
    logic           b_busy, b_wr_out, b_done;
    logic [CH*DW-1:0] b_bus;
    logic [AW-1:0]  b_oaddr;

    pool_layer_np #(
        .DATA_WIDTH(DW), .CH_NUM(CH), .ADDR_WIDTH(AW),
        .IN_W(4), .IN_H(4), .POOL_K(2), .STRIDE(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .layer_enable(a_en), .pool_mode(a_mode),
        .in_wr_en(a_wr), .in_addr(a_addr), .in_data_bus(a_din),
        .busy(a_busy), .out_bus(a_bus), .out_addr(a_oaddr),
        .out_wr_en(a_wr_out), .layer_done(a_done)
    );

    pool_layer_np #(
        .DATA_WIDTH(DW), .CH_NUM(CH), .ADDR_WIDTH(AW),
        .IN_W(3), .IN_H(3), .POOL_K(2), .STRIDE(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .layer_enable(b_en), .pool_mode(b_mode),
        .in_wr_en(b_wr), .in_addr(b_addr), .in_data_bus(b_din),
        .busy(b_busy), .out_bus(b_bus), .out_addr(b_oaddr),
        .out_wr_en(b_wr_out), .layer_done(b_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_err = 0;

    int qa_addr[$], qa_c0[$], qa_c1[$], qa_cyc[$], qa_done[$];
    int qb_addr[$], qb_c0[$], qb_c1[$], qb_cyc[$], qb_done[$];
    int a_busy_cnt = 0;
    int b_busy_cnt = 0;

    int ref_mem [16][2];
    int eq0[$], eq1[$];

    int k_max0[4] = '{5, 7, 13, 15};
    int k_max1[4] = '{0, -2, -8, -10};
    int k_avg0[4] = '{2, 4, 10, 12};
    int k_avg1[4] = '{-3, -5, -11, -13};
    int k_b0[4]   = '{4, 5, 7, 8};

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (a_wr_out) begin
            qa_addr.push_back(int'(a_oaddr));
            qa_c0.push_back(int'($signed(a_bus[DW-1:0])));
            qa_c1.push_back(int'($signed(a_bus[2*DW-1:DW])));
            qa_cyc.push_back(cyc);
        end
        if (a_done) qa_done.push_back(cyc);
        if (a_busy) a_busy_cnt++;
        if (b_wr_out) begin
            qb_addr.push_back(int'(b_oaddr));
            qb_c0.push_back(int'($signed(b_bus[DW-1:0])));
            qb_c1.push_back(int'($signed(b_bus[2*DW-1:DW])));
            qb_cyc.push_back(cyc);
        end
        if (b_done) qb_done.push_back(cyc);
        if (b_busy) b_busy_cnt++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        qa_addr.delete(); qa_c0.delete(); qa_c1.delete(); qa_cyc.delete(); qa_done.delete();
        qb_addr.delete(); qb_c0.delete(); qb_c1.delete(); qb_cyc.delete(); qb_done.delete();
        a_busy_cnt = 0;
        b_busy_cnt = 0;
    endtask

    task automatic load(input bit sel, input int addr, input int v0, input int v1);
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        d0 = v0[DW-1:0];
        d1 = v1[DW-1:0];
        if (sel) begin
            b_wr = 1'b1; b_addr = AW'(addr); b_din = {d1, d0};
        end else begin
            a_wr = 1'b1; a_addr = AW'(addr); a_din = {d1, d0};
        end
        tick();
        a_wr = 1'b0;
        b_wr = 1'b0;
    endtask

    // Floor division for signed sums (rounds toward minus infinity).
    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    // Reference: walk every window, take max or floored mean per channel.
    function automatic void model(input int inw, input int inh, input int k, input int s, input bit avg);
        int ow;
        int oh;
        ow = (inw - k) / s + 1;
        oh = (inh - k) / s + 1;
        eq0.delete();
        eq1.delete();
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                for (int c = 0; c < 2; c++) begin
                    int sum;
                    int mx;
                    int r;
                    sum = 0;
                    mx = -100000;
                    for (int ky = 0; ky < k; ky++) begin
                        for (int kx = 0; kx < k; kx++) begin
                            int v;
                            v = ref_mem[(oy * s + ky) * inw + ox * s + kx][c];
                            sum += v;
                            if (v > mx) mx = v;
                        end
                    end
                    r = avg ? floor_div(sum, k * k) : mx;
                    if (c == 0) eq0.push_back(r);
                    else eq1.push_back(r);
                end
            end
        end
    endfunction

    task automatic start(input bit sel, input bit mode, output int c0);
        if (sel) begin b_en = 1'b1; b_mode = mode; end
        else begin a_en = 1'b1; a_mode = mode; end
        @(posedge clk);
        #1;
        c0 = cyc;
        a_en = 1'b0;
        b_en = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        for (int i = 0; i < 200 && (sel ? qb_done.size() : qa_done.size()) == 0; i++) tick();
        if ((sel ? qb_done.size() : qa_done.size()) == 0) check("done_timeout", 0, 1);
        repeat (3) tick();
    endtask

    task automatic check_pass(input bit sel, input bit avg, input int c0);
        int inw;
        int s;
        int n;
        int dn;
        int dc;
        int bc;
        inw = sel ? 3 : 4;
        s = sel ? 1 : 2;
        model(inw, inw, 2, s, avg);
        n = sel ? qb_addr.size() : qa_addr.size();
        check("out_count", n, eq0.size());
        for (int i = 0; i < n && i < eq0.size(); i++) begin
            check("out_addr", sel ? qb_addr[i] : qa_addr[i], i);
            check("ch0", sel ? qb_c0[i] : qa_c0[i], eq0[i]);
            check("ch1", sel ? qb_c1[i] : qa_c1[i], eq1[i]);
            check("out_cycle", (sel ? qb_cyc[i] : qa_cyc[i]) - c0, 5 + 4 * i);
        end
        dn = sel ? qb_done.size() : qa_done.size();
        check("done_pulses", dn, 1);
        if (dn > 0) begin
            dc = (sel ? qb_done[0] : qa_done[0]) - c0;
            bc = sel ? b_busy_cnt : a_busy_cnt;
            check("done_cycle", dc, 5 + 4 * (eq0.size() - 1) + 1);
            check("busy_cycles", bc, dc + 1);
        end
    endtask

    task automatic const_check_a(input bit avg);
        for (int i = 0; i < 4 && i < qa_c0.size(); i++) begin
            check("ref_ch0", qa_c0[i], avg ? k_avg0[i] : k_max0[i]);
            check("ref_ch1", qa_c1[i], avg ? k_avg1[i] : k_max1[i]);
        end
    endtask

    initial begin
        int c0;
        int v;
        rst_n = 1'b0;
        a_en = 0; a_mode = 0; a_wr = 0; a_addr = '0; a_din = '0;
        b_en = 0; b_mode = 0; b_wr = 0; b_addr = '0; b_din = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", a_busy, 0);
        check("rst_wr_en", a_wr_out, 0);
        check("rst_done", a_done, 0);
        check("rst_out_addr", a_oaddr, 0);
        check("rst_out_bus", a_bus, 0);
        rst_n = 1'b1;
        tick();

        // Ramp pattern: ch0 = addr, ch1 = -addr
        for (int i = 0; i < 16; i++) begin
            load(0, i, i, -i);
            ref_mem[i][0] = i;
            ref_mem[i][1] = -i;
        end

        clear_caps(); start(0, 0, c0); wait_done(0);
        check_pass(0, 0, c0); const_check_a(0);

        clear_caps(); start(0, 1, c0); wait_done(0);
        check_pass(0, 1, c0); const_check_a(1);

        // Restart request and buffer write while scanning must both be dropped
        clear_caps(); start(0, 0, c0);
        repeat (3) tick();
        a_en = 1'b1; a_mode = 1'b1; a_wr = 1'b1; a_addr = '0; a_din = 32'h7FFF_7FFF;
        tick();
        a_en = 1'b0; a_wr = 1'b0;
        wait_done(0);
        check_pass(0, 0, c0); const_check_a(0);
        clear_caps(); start(0, 0, c0); wait_done(0);
        check_pass(0, 0, c0); const_check_a(0);

        // Reset after the second output
        clear_caps(); start(0, 0, c0);
        for (int i = 0; i < 100 && qa_addr.size() < 2; i++) tick();
        check("outputs_before_reset", qa_addr.size(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_wr_en", a_wr_out, 0);
        check("mid_rst_done", a_done, 0);
        check("mid_rst_out_addr", a_oaddr, 0);
        check("mid_rst_out_bus", a_bus, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        clear_caps(); start(0, 0, c0); wait_done(0);
        check_pass(0, 0, c0); const_check_a(0);

        // Random buffer contents and modes
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                ref_mem[i][0] = int'($urandom_range(0, 65535)) - 32768;
                ref_mem[i][1] = int'($urandom_range(0, 65535)) - 32768;
                load(0, i, ref_mem[i][0], ref_mem[i][1]);
            end
            v = int'($urandom_range(0, 1));
            clear_caps(); start(0, v[0], c0); wait_done(0);
            check_pass(0, v[0], c0);
        end

        // 3x3, stride 1 instance; out-of-range writes must be dropped
        for (int i = 0; i < 16; i++) begin
            ref_mem[i][0] = 0;
            ref_mem[i][1] = 0;
        end
        for (int i = 0; i < 9; i++) begin
            ref_mem[i][0] = i;
            ref_mem[i][1] = int'($urandom_range(0, 65535)) - 32768;
            load(1, i, ref_mem[i][0], ref_mem[i][1]);
        end
        load(1, 9, 32767, 32767);
        load(1, 16, 32767, 32767);
        clear_caps(); start(1, 0, c0); wait_done(1);
        check_pass(1, 0, c0);
        for (int i = 0; i < 4 && i < qb_c0.size(); i++) check("b_ref_ch0", qb_c0[i], k_b0[i]);
        clear_caps(); start(1, 1, c0); wait_done(1);
        check_pass(1, 1, c0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pool_layer_np.md
POOL_LAYER_NP -- requirements
Module: pool_layer_np

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed per-channel sample width.
REQ-002 SHALL have parameter CH_NUM, default 6, meaning number of channels pooled in parallel.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning width of input and output address ports.
REQ-004 SHALL have parameters IN_W and IN_H, default 28 and 28, meaning input feature map width and height.
REQ-005 SHALL have parameters POOL_K and STRIDE, default 2 and 2; POOL_K SHALL be a power of two, and any other value is an elaboration error.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port layer_enable, input, 1 bit, start request.
REQ-009 SHALL have port pool_mode, input, 1 bit: 0 = max, 1 = average; sampled with layer_enable.
REQ-010 SHALL have ports in_wr_en (1 bit), in_addr (ADDR_WIDTH) and in_data_bus (CH_NUM*DATA_WIDTH), all inputs, for loading the input buffer; channel j occupies bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j].
REQ-011 SHALL have port busy, output, 1 bit, high while a layer pass runs.
REQ-012 SHALL have ports out_bus (CH_NUM*DATA_WIDTH), out_addr (ADDR_WIDTH) and out_wr_en (1 bit), all outputs, for the downstream buffer.
REQ-013 SHALL have port layer_done, output, 1 bit, one-cycle completion pulse.

Function
REQ-014 SHALL hold an internal buffer of IN_W*IN_H words of CH_NUM*DATA_WIDTH bits, with synchronous read and 1-cycle read latency.
REQ-015 SHALL write in_data_bus to in_addr when in_wr_en=1, busy=0 and in_addr < IN_W*IN_H; the write SHALL be silently ignored in every other case.
REQ-016 SHALL implement states IDLE -> SCAN -> DONE -> IDLE.
REQ-017 IDLE: layer_enable=1 SHALL latch pool_mode, enter SCAN and set busy=1 at that edge (edge E0).
REQ-018 SHALL ignore layer_enable while busy=1.
REQ-019 SHALL define OUT_W=(IN_W-POOL_K)/STRIDE+1 and OUT_H=(IN_H-POOL_K)/STRIDE+1.
REQ-020 SCAN SHALL visit outputs in row-major (oy, ox) order and each window in row-major (ky, kx) order, issuing one read per cycle at (oy*STRIDE+ky)*IN_W + ox*STRIDE+kx, with no bubbles between windows.
REQ-021 Max mode SHALL produce the signed maximum per channel.
REQ-022 Average mode SHALL sum per channel in an accumulator of DATA_WIDTH+2*log2(POOL_K) bits, then arithmetic-shift right by 2*log2(POOL_K) (floor), keeping the low DATA_WIDTH bits.
REQ-023 The first output SHALL be registered so that out_wr_en=1 in the cycle following the (POOL_K*POOL_K+1)th rising edge after E0; later outputs SHALL follow every POOL_K*POOL_K cycles.
REQ-024 out_wr_en SHALL be high for exactly one cycle per output, with out_bus and out_addr valid in that cycle.
REQ-025 out_addr SHALL be 0 for the first output of each pass and increment by 1 per output, ending at OUT_W*OUT_H-1.
REQ-026 After the final output, SHALL enter DONE, pulse layer_done=1 for one cycle in the next cycle, clear busy with layer_done, then return to IDLE.
REQ-027 A layer_enable arriving in the same cycle as layer_done SHALL be ignored.

Reset
REQ-028 On rst_n=0, the block SHALL go to IDLE asynchronously, including mid-pass, with busy=0, layer_done=0, out_wr_en=0, out_addr=0 and out_bus=0; the latched mode SHALL reset to max.
REQ-029 Input buffer contents SHALL NOT be cleared by reset.
REQ-030 Any pass interrupted by reset SHALL be abandoned; the next pass SHALL start from out_addr 0.

Verification (IN_W=IN_H=4, POOL_K=2, STRIDE=2, CH_NUM=2, DATA_WIDTH=16 unless noted; load ch0=addr, ch1=-addr for addr 0..15)
REQ-031 Max mode -> ch0 outputs 5, 7, 13, 15 and ch1 outputs 0, -2, -8, -10, at out_addr 0..3.
REQ-032 Average mode -> ch0 outputs 2, 4, 10, 12 and ch1 outputs -3, -5, -11, -13.
REQ-033 Timing -> first out_wr_en in the cycle after the 5th edge following E0; four pulses spaced 4 cycles apart; layer_done one cycle after the last pulse; busy high from E0 through layer_done.
REQ-034 During SCAN, pulse layer_enable and write 0x7FFF to addr 0 -> no restart and no write; a rerun after done gives identical outputs.
REQ-035 Assert rst_n=0 after the 2nd output -> all outputs go to 0 immediately; a new layer_enable gives 4 outputs starting at out_addr 0 from the retained buffer.
REQ-036 IN_W=IN_H=3, STRIDE=1, ch0=addr, max mode -> outputs 4, 5, 7, 8; a write with in_addr=9 is ignored.
